// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and width constants for the FIFO write arbiter
// Purpose: FSM state type plus default data width and FIFO geometry constants.
// Ports: none (package).
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam int DEF_DATA_W = 8;
  localparam int FIFO_AW    = 4;
  // Address plus wrap bit, the pointer width the downstream FIFO uses.
  localparam int FIFO_PTR_W = FIFO_AW + 1;
  localparam int FIFO_DEPTH = 1 << FIFO_AW;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - producer/FIFO write-side bundle for the arbiter
// Purpose: groups producer requests, FIFO status and FIFO write outputs.
// Signals: req/req_data/fifo_full into the arbiter; ack/gnt/wr/data_in/busy out.
// Modports: master = arbiter side, slave = producers + FIFO side.
interface fifo_wr_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = DEF_DATA_W
);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic                      fifo_full;
  logic [NUM_REQ-1:0]        ack;
  logic [NUM_REQ-1:0]        gnt;
  logic                      wr;
  logic [DATA_W-1:0]         data_in;
  logic                      busy;

  modport master (
    input  req, req_data, fifo_full,
    output ack, gnt, wr, data_in, busy
  );

  modport slave (
    output req, req_data, fifo_full,
    input  ack, gnt, wr, data_in, busy
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rtl/fifo_wr_arbiter_rr_pick.sv - combinational round-robin priority encoder
// Purpose: pick the first set request scanning last+1, last+2, ... modulo NUM_REQ.
// Ports: i_req (request vector), i_last (last-grant pointer),
//        o_pick (one-hot pick), o_idx (pick index), o_any (any request set).
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_last,
  output logic [NUM_REQ-1:0] o_pick,
  output logic [PTR_W-1:0]   o_idx,
  output logic               o_any
);

  logic [PTR_W-1:0] w_cand;

  // The last-granted index is checked last (k = NUM_REQ), so it has lowest priority.
  always_comb begin
    o_pick = '0;
    o_idx  = '0;
    o_any  = 1'b0;
    w_cand = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = PTR_W'((int'(i_last) + k) % NUM_REQ);
      if (!o_any && i_req[w_cand]) begin
        o_any          = 1'b1;
        o_idx          = w_cand;
        o_pick[w_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter for the shared FIFO write port
// Purpose: grant one producer at a time for up to MAX_BURST writes, never write while full.
// Ports: clk, rst_n (async active-low), bus (fifo_wr_arbiter_if.master):
//        req/req_data/fifo_full in; ack (comb one-hot), gnt (registered one-hot),
//        wr, data_in, busy out.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  fifo_wr_arbiter_if.master  bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  state_t               r_state, w_state_nxt;
  logic [NUM_REQ-1:0]   r_gnt, w_gnt_nxt;
  logic [PTR_W-1:0]     r_ptr, w_ptr_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt, w_cnt_inc;

  logic [NUM_REQ-1:0]   w_pick;
  logic [PTR_W-1:0]     w_pick_idx;
  logic                 w_any;
  logic                 w_req_g;
  logic                 w_wr;
  logic [DATA_W-1:0]    w_data;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .i_req   (bus.req),
    .i_last  (r_ptr),
    .o_pick  (w_pick),
    .o_idx   (w_pick_idx),
    .o_any   (w_any)
  );

  // While in BURST the pointer holds the granted index, so it doubles as g.
  assign w_req_g   = bus.req[r_ptr];
  assign w_wr      = (r_state == BURST) && w_req_g && !bus.fifo_full;
  assign w_cnt_inc = r_cnt + CNT_W'(1);

  always_comb begin
    w_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_ptr == PTR_W'(i)) begin
        w_data = bus.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign bus.wr      = w_wr;
  assign bus.ack     = w_wr ? r_gnt : '0;
  assign bus.gnt     = r_gnt;
  assign bus.data_in = w_data;
  assign bus.busy    = (r_state == BURST);

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt = BURST;
          w_gnt_nxt   = w_pick;
          w_ptr_nxt   = w_pick_idx;
          w_cnt_nxt   = '0;
        end
      end
      BURST: begin
        if (w_wr) begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == CNT_W'(MAX_BURST)) begin
            w_state_nxt = IDLE;
            w_gnt_nxt   = '0;
          end
        end else if (!w_req_g) begin
          // Producer withdrew; a full-stall (req high) keeps the grant.
          w_state_nxt = IDLE;
          w_gnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_ptr   <= PTR_W'(NUM_REQ - 1);
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

endmodule
